// File: rtl/mem_access_sequencer_pkg.sv
// Shared LC-3b types for the memory-stage sequencer.
// Opcode encoding plus sequencer state and opcode class helpers.
package lc3b_types;

    typedef enum logic [3:0] {
        op_br   = 4'b0000,
        op_add  = 4'b0001,
        op_ldb  = 4'b0010,
        op_stb  = 4'b0011,
        op_jsr  = 4'b0100,
        op_and  = 4'b0101,
        op_ldr  = 4'b0110,
        op_str  = 4'b0111,
        op_rti  = 4'b1000,
        op_not  = 4'b1001,
        op_ldi  = 4'b1010,
        op_sti  = 4'b1011,
        op_jmp  = 4'b1100,
        op_shf  = 4'b1101,
        op_lea  = 4'b1110,
        op_trap = 4'b1111
    } lc3b_opcode;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ACC1 = 2'b01,
        ACC2 = 2'b10,
        DONE = 2'b11
    } seq_state_t;

    function automatic logic is_mem_op(lc3b_opcode op);
        return op inside {op_ldr, op_str, op_ldb, op_stb,
                          op_ldi, op_sti, op_trap};
    endfunction

    function automatic logic is_byte_op(lc3b_opcode op);
        return op inside {op_ldb, op_stb};
    endfunction

    function automatic logic is_indirect(lc3b_opcode op);
        return op inside {op_ldi, op_sti};
    endfunction

    // Stores whose only access is the write itself
    function automatic logic is_direct_store(lc3b_opcode op);
        return op inside {op_str, op_stb};
    endfunction

endpackage

// File: rtl/mem_access_sequencer_if.sv
// Data-memory port bundle between the sequencer and memory.
// master drives strobes/address/data, slave answers with resp/rdata.
interface mem_access_sequencer_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic                  mem_read;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [BE_WIDTH-1:0]   mem_byte_enable;
    logic                  mem_resp;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_read, mem_write, mem_address,
        output mem_wdata, mem_byte_enable,
        input  mem_resp, mem_rdata
    );

    modport slave (
        input  mem_read, mem_write, mem_address,
        input  mem_wdata, mem_byte_enable,
        output mem_resp, mem_rdata
    );

endinterface

// File: rtl/mem_access_sequencer_byte_lane_align.sv
// Byte-lane steering for LDB/STB.
// Lane is chosen by address bit 0 only.
module byte_lane_align #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                    lane,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   load_byte,
    output logic [DATA_WIDTH/8-1:0] byte_enable,
    output logic [DATA_WIDTH-1:0]   store_word
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] shifted;
    logic [7:0]            sel_byte;

    // Pick the addressed byte, sign-extend it, replicate the store byte
    always_comb begin
        shifted     = rdata >> (lane ? 8 : 0);
        sel_byte    = shifted[7:0];
        load_byte   = DATA_WIDTH'(signed'(sel_byte));
        store_word  = {BE_WIDTH{wdata[7:0]}};
        byte_enable = BE_WIDTH'(1) << lane;
    end

endmodule

// File: rtl/mem_access_sequencer.sv
// LC-3b MEM-stage sequencer for single and double memory accesses.
// Holds the pipeline in stall until all accesses get mem_resp.
module mem_access_sequencer
    import lc3b_types::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  lc3b_opcode            opcode,
    input  logic [ADDR_WIDTH-1:0] eff_addr,
    input  logic [DATA_WIDTH-1:0] store_data,
    mem_access_sequencer_if.master mem,
    output logic                  stall,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    seq_state_t            state_q, state_d;
    lc3b_opcode            op_q, op_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0] sdata_q, sdata_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;

    logic [DATA_WIDTH-1:0] load_byte;
    logic [DATA_WIDTH-1:0] store_word;
    logic [BE_WIDTH-1:0]   lane_be;
    logic [ADDR_WIDTH-1:0] rd_ptr;

    byte_lane_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_lane (
        .lane        (addr_q[0]),
        .rdata       (mem.mem_rdata),
        .wdata       (sdata_q),
        .load_byte   (load_byte),
        .byte_enable (lane_be),
        .store_word  (store_word)
    );

    // Pointer fetched in ACC1 is a word address
    always_comb begin
        rd_ptr    = ADDR_WIDTH'(mem.mem_rdata);
        rd_ptr[0] = 1'b0;
    end

    // State and latched operands
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= op_br;
            addr_q   <= '0;
            ptr_q    <= '0;
            sdata_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            ptr_q    <= ptr_d;
            sdata_q  <= sdata_d;
            result_q <= result_d;
        end
    end

    // Next state, operand capture and memory port drive
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        addr_d   = addr_q;
        ptr_d    = ptr_q;
        sdata_d  = sdata_q;
        result_d = result_q;

        stall               = 1'b0;
        done                = 1'b0;
        result              = '0;
        mem.mem_read        = 1'b0;
        mem.mem_write       = 1'b0;
        mem.mem_address     = '0;
        mem.mem_wdata       = '0;
        mem.mem_byte_enable = '0;

        unique case (state_q)
            IDLE: begin
                if (start && is_mem_op(opcode)) begin
                    stall    = 1'b1;
                    op_d     = opcode;
                    addr_d   = eff_addr;
                    sdata_d  = store_data;
                    result_d = '0;
                    state_d  = ACC1;
                end
            end
            ACC1: begin
                stall         = 1'b1;
                mem.mem_write = is_direct_store(op_q);
                mem.mem_read  = !is_direct_store(op_q);
                if (is_byte_op(op_q)) begin
                    mem.mem_address     = addr_q;
                    mem.mem_byte_enable = lane_be;
                end else begin
                    mem.mem_address     = {addr_q[ADDR_WIDTH-1:1], 1'b0};
                    mem.mem_byte_enable = '1;
                end
                if (op_q == op_stb) begin
                    mem.mem_wdata = store_word;
                end else if (op_q == op_str) begin
                    mem.mem_wdata = sdata_q;
                end
                if (mem.mem_resp) begin
                    if (is_indirect(op_q)) begin
                        ptr_d   = rd_ptr;
                        state_d = ACC2;
                    end else begin
                        if (op_q == op_ldb) begin
                            result_d = load_byte;
                        end else if (!is_direct_store(op_q)) begin
                            result_d = mem.mem_rdata;
                        end
                        state_d = DONE;
                    end
                end
            end
            ACC2: begin
                stall               = 1'b1;
                mem.mem_read        = (op_q == op_ldi);
                mem.mem_write       = (op_q == op_sti);
                mem.mem_address     = ptr_q;
                mem.mem_byte_enable = '1;
                if (op_q == op_sti) begin
                    mem.mem_wdata = sdata_q;
                end
                if (mem.mem_resp) begin
                    if (op_q == op_ldi) begin
                        result_d = mem.mem_rdata;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                result  = result_q;
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Self-checking bench for mem_access_sequencer.
// Directed vector table, random transactions vs a reference model.
module tb_mem_access_sequencer;
    import lc3b_types::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    lc3b_opcode  opcode;
    logic [15:0] eff_addr;
    logic [15:0] store_data;
    logic        stall;
    logic        done;
    logic [15:0] result;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    mem_access_sequencer_if #(
        .ADDR_WIDTH (16),
        .DATA_WIDTH (16)
    ) mem ();

    mem_access_sequencer #(
        .ADDR_WIDTH (16),
        .DATA_WIDTH (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .opcode     (opcode),
        .eff_addr   (eff_addr),
        .store_data (store_data),
        .mem        (mem),
        .stall      (stall),
        .done       (done),
        .result     (result)
    );

    typedef struct {
        int          lat;
        int          nacc;
        logic [15:0] a1;
        logic [15:0] a2;
        logic [15:0] wdata;
        logic [1:0]  be;
        logic [15:0] res;
    } exp_t;

    typedef struct {
        lc3b_opcode  op;
        logic [15:0] ea;
        logic [15:0] sd;
        logic [15:0] rd1;
        logic [15:0] rd2;
        int          w1;
        int          w2;
        exp_t        e;
    } vec_t;

    typedef struct {
        int               lat;
        int               nacc;
        logic [1:0][15:0] addr;
        logic [1:0]       wr;
        logic [1:0][15:0] wdata;
        logic [1:0][1:0]  be;
        logic [15:0]      res;
        int               hold_bad;
        int               stall_bad;
        int               strobe_bad;
        logic             stall0;
    } obs_t;

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic vec_t mk(lc3b_opcode op, logic [15:0] ea,
                                logic [15:0] sd, logic [15:0] rd1,
                                logic [15:0] rd2, int w1, int w2,
                                int nacc, logic [15:0] a1,
                                logic [15:0] a2, logic [15:0] wd,
                                logic [1:0] be, logic [15:0] res,
                                int lat);
        vec_t v;
        v.op = op; v.ea = ea; v.sd = sd;
        v.rd1 = rd1; v.rd2 = rd2; v.w1 = w1; v.w2 = w2;
        v.e.nacc = nacc; v.e.a1 = a1; v.e.a2 = a2;
        v.e.wdata = wd; v.e.be = be; v.e.res = res; v.e.lat = lat;
        return v;
    endfunction

    // Reference: what the instruction must do, from the ISA rules
    function automatic exp_t ref_model(vec_t v);
        exp_t e;
        int   b;
        bit   byte_op;
        byte_op = (v.op == op_ldb) || (v.op == op_stb);
        e.nacc  = (v.op == op_ldi || v.op == op_sti) ? 2 : 1;
        e.a1    = byte_op ? v.ea : (v.ea & 16'hFFFE);
        e.a2    = v.rd1 & 16'hFFFE;
        e.be    = byte_op ? ((v.ea % 2 == 1) ? 2'b10 : 2'b01) : 2'b11;
        e.wdata = (v.op == op_stb) ? (v.sd & 16'h00FF) * 16'h0101
                                   : v.sd;
        b = (v.ea % 2 == 1) ? (v.rd1 / 256) : (v.rd1 % 256);
        case (v.op)
            op_ldb:          e.res = 16'(b >= 128 ? b + 16'hFF00 : b);
            op_ldi:          e.res = v.rd2;
            op_ldr, op_trap: e.res = v.rd1;
            default:         e.res = 16'h0000;
        endcase
        e.lat = 1 + (v.w1 + 1) + ((e.nacc == 2) ? (v.w2 + 1) : 0);
        return e;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n        = 1'b0;
        start        = 1'b0;
        mem.mem_resp = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Issue one instruction and act as memory with per-access waits
    task automatic run_txn(input vec_t v, output obs_t o);
        int          acc_w [2];
        logic [15:0] acc_rd [2];
        int          cnt;
        int          idx;
        bit          pending;
        bit          fin;
        acc_w[0] = v.w1;  acc_w[1] = v.w2;
        acc_rd[0] = v.rd1; acc_rd[1] = v.rd2;
        o.lat = -1; o.nacc = 0; o.addr = '0; o.wr = '0;
        o.wdata = '0; o.be = '0; o.res = '0;
        o.hold_bad = 0; o.stall_bad = 0; o.strobe_bad = 0;
        @(negedge clk);
        start        = 1'b1;
        opcode       = v.op;
        eff_addr     = v.ea;
        store_data   = v.sd;
        mem.mem_resp = 1'b0;
        #1;
        o.stall0 = stall;
        if (mem.mem_read || mem.mem_write || done) o.strobe_bad++;
        pending = 0; cnt = 0; fin = 0;
        for (int n = 1; n <= 60 && !fin; n++) begin
            @(negedge clk);
            start        = 1'($urandom);
            opcode       = lc3b_opcode'(4'($urandom));
            eff_addr     = 16'($urandom);
            store_data   = 16'($urandom);
            mem.mem_resp = 1'b0;
            mem.mem_rdata = 16'($urandom);
            #1;
            if (done) begin
                fin   = 1;
                o.lat = n;
                o.res = result;
                if (stall || mem.mem_read || mem.mem_write)
                    o.strobe_bad++;
                mem.mem_resp = 1'($urandom);
            end else if (mem.mem_read ^ mem.mem_write) begin
                if (!stall) o.stall_bad++;
                if (!pending) begin
                    if (o.nacc < 2) begin
                        o.addr[o.nacc]  = mem.mem_address;
                        o.wr[o.nacc]    = mem.mem_write;
                        o.wdata[o.nacc] = mem.mem_wdata;
                        o.be[o.nacc]    = mem.mem_byte_enable;
                    end
                    o.nacc++;
                    cnt = 0;
                end
                idx = (o.nacc > 2) ? 1 : o.nacc - 1;
                if (pending &&
                    (o.addr[idx] !== mem.mem_address ||
                     o.wr[idx] !== mem.mem_write ||
                     o.wdata[idx] !== mem.mem_wdata ||
                     o.be[idx] !== mem.mem_byte_enable))
                    o.hold_bad++;
                if (cnt >= acc_w[idx]) begin
                    mem.mem_resp  = 1'b1;
                    mem.mem_rdata = acc_rd[idx];
                    pending = 0;
                end else begin
                    pending = 1;
                    cnt++;
                end
            end else begin
                o.strobe_bad++;
            end
        end
        start = 1'b0;
        if (!fin) begin
            $display("FAIL timeout: no done for opcode %0h", v.op);
            do_reset();
        end
    endtask

    task automatic check_txn(string tag, vec_t v, obs_t o);
        exp_t e;
        int   wi;
        e  = v.e;
        wi = (v.op == op_sti) ? 1 : 0;
        chk({tag, " latency"}, o.lat, e.lat);
        chk({tag, " accesses"}, o.nacc, e.nacc);
        chk({tag, " start_stall"}, o.stall0, 1);
        chk({tag, " addr1"}, o.addr[0], e.a1);
        chk({tag, " write1"}, o.wr[0],
            (v.op == op_str || v.op == op_stb) ? 1 : 0);
        if (e.nacc == 2) begin
            chk({tag, " addr2"}, o.addr[1], e.a2);
            chk({tag, " write2"}, o.wr[1], (v.op == op_sti) ? 1 : 0);
            chk({tag, " be2"}, o.be[1], 2'b11);
        end
        if (v.op != op_ldb)
            chk({tag, " be1"}, o.be[0], e.be);
        if (v.op inside {op_str, op_stb, op_sti}) begin
            chk({tag, " wdata"}, o.wdata[wi], e.wdata);
            if (v.op == op_stb)
                chk({tag, " stb_be"}, o.be[0], e.be);
        end else begin
            chk({tag, " result"}, o.res, e.res);
        end
        chk({tag, " held"}, o.hold_bad, 0);
        chk({tag, " stall"}, o.stall_bad, 0);
        chk({tag, " strobes"}, o.strobe_bad, 0);
    endtask

    vec_t       vt [10];
    vec_t       rv;
    obs_t       ob;
    lc3b_opcode mem_ops [7];
    int         bad;

    initial begin
        vt[0] = mk(op_ldr, 16'h3005, 16'h0000, 16'hBEEF, 16'h0000,
                   3, 0, 1, 16'h3004, 16'h0000, 16'h0000, 2'b11,
                   16'hBEEF, 5);
        vt[1] = mk(op_ldi, 16'h2000, 16'h0000, 16'h4000, 16'h1234,
                   0, 0, 2, 16'h2000, 16'h4000, 16'h0000, 2'b11,
                   16'h1234, 3);
        vt[2] = mk(op_stb, 16'h1001, 16'h00A5, 16'h0000, 16'h0000,
                   0, 0, 1, 16'h1001, 16'h0000, 16'hA5A5, 2'b10,
                   16'h0000, 2);
        vt[3] = mk(op_ldb, 16'h1000, 16'h0000, 16'h7F80, 16'h0000,
                   0, 0, 1, 16'h1000, 16'h0000, 16'h0000, 2'b01,
                   16'hFF80, 2);
        vt[4] = mk(op_ldb, 16'h1001, 16'h0000, 16'h8012, 16'h0000,
                   1, 0, 1, 16'h1001, 16'h0000, 16'h0000, 2'b10,
                   16'hFF80, 3);
        vt[5] = mk(op_sti, 16'h0040, 16'h1357, 16'h5002, 16'h0000,
                   1, 2, 2, 16'h0040, 16'h5002, 16'h1357, 2'b11,
                   16'h0000, 6);
        vt[6] = mk(op_trap, 16'h0046, 16'h0000, 16'h0400, 16'h0000,
                   0, 0, 1, 16'h0046, 16'h0000, 16'h0000, 2'b11,
                   16'h0400, 2);
        vt[7] = mk(op_str, 16'h1235, 16'hCAFE, 16'h0000, 16'h0000,
                   2, 0, 1, 16'h1234, 16'h0000, 16'hCAFE, 2'b11,
                   16'h0000, 4);
        vt[8] = mk(op_stb, 16'h2000, 16'h1234, 16'h0000, 16'h0000,
                   0, 0, 1, 16'h2000, 16'h0000, 16'h3434, 2'b01,
                   16'h0000, 2);
        vt[9] = mk(op_ldi, 16'h3001, 16'h0000, 16'h6000, 16'h8001,
                   2, 1, 2, 16'h3000, 16'h6000, 16'h0000, 2'b11,
                   16'h8001, 6);

        mem_ops = '{op_ldr, op_str, op_ldb, op_stb,
                    op_ldi, op_sti, op_trap};

        rst_n         = 1'b0;
        start         = 1'b0;
        opcode        = op_br;
        eff_addr      = '0;
        store_data    = '0;
        mem.mem_resp  = 1'b0;
        mem.mem_rdata = '0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst stall", stall, 0);
        chk("rst done", done, 0);
        chk("rst result", result, 0);
        chk("rst strobes", {mem.mem_read, mem.mem_write}, 0);
        chk("rst addr", mem.mem_address, 0);
        chk("rst wdata", mem.mem_wdata, 0);
        chk("rst be", mem.mem_byte_enable, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vector table
        foreach (vt[i]) begin
            run_txn(vt[i], ob);
            check_txn($sformatf("vec%0d", i), vt[i], ob);
        end

        // Non-memory opcode with start, and stray mem_resp in IDLE
        @(negedge clk);
        start        = 1'b1;
        opcode       = op_add;
        mem.mem_resp = 1'b1;
        #1;
        chk("add stall", stall, 0);
        chk("add strobes", {mem.mem_read, mem.mem_write}, 0);
        bad = 0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            start        = 1'b0;
            opcode       = op_ldr;
            mem.mem_resp = 1'($urandom);
            #1;
            if (done || stall || mem.mem_read || mem.mem_write)
                bad++;
        end
        chk("add idle", bad, 0);
        mem.mem_resp = 1'b0;

        // STI interrupted by reset during the ACC2 wait
        @(negedge clk);
        start      = 1'b1;
        opcode     = op_sti;
        eff_addr   = 16'h0100;
        store_data = 16'h7777;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("sti ptr read", mem.mem_read, 1);
        chk("sti ptr addr", mem.mem_address, 16'h0100);
        mem.mem_resp  = 1'b1;
        mem.mem_rdata = 16'h5002;
        @(negedge clk);
        mem.mem_resp = 1'b0;
        #1;
        chk("sti write", mem.mem_write, 1);
        chk("sti addr", mem.mem_address, 16'h5002);
        chk("sti wdata", mem.mem_wdata, 16'h7777);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("sti write held", mem.mem_write, 1);
        @(posedge clk);
        #1;
        chk("sti rst write", mem.mem_write, 0);
        chk("sti rst read", mem.mem_read, 0);
        chk("sti rst stall", stall, 0);
        chk("sti rst done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            #1;
            if (done || mem.mem_read || mem.mem_write) bad++;
        end
        chk("sti no done", bad, 0);

        // Random transactions against the reference model
        for (int k = 0; k < 60; k++) begin
            rv.op  = mem_ops[$urandom_range(0, 6)];
            rv.ea  = 16'($urandom);
            rv.sd  = 16'($urandom);
            rv.rd1 = 16'($urandom);
            rv.rd2 = 16'($urandom);
            if (rv.op == op_ldi || rv.op == op_sti)
                rv.rd1[0] = 1'b0;
            rv.w1  = $urandom_range(0, 3);
            rv.w2  = $urandom_range(0, 3);
            rv.e   = ref_model(rv);
            run_txn(rv, ob);
            check_txn($sformatf("rnd%0d", k), rv, ob);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
